// File: rtl/c1541_drive_seq.sv
// c1541_drive_seq: converts stepper phases to a half-track position and
// spins a virtual disk over the per-track GCR buffer.
// Ports: clk32/reset_n (sync, active-low); mtr, mode, soe, stp, speed_zone,
// dout from the drive logic; din, sync_n, byte_n, tr00_sense_n, half_track,
// track_change back to it; track_ready/track_len from the image loader;
// buf_addr/buf_rd/buf_rdata/buf_wr/buf_wdata to the track buffer RAM.
module c1541_drive_seq #(
  parameter int HT_MAX   = 84,
  parameter int HT_RESET = 34,
  parameter int BRDY_LEN = 64
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        mtr,
  input  logic        mode,
  input  logic        soe,
  input  logic [1:0]  stp,
  input  logic [1:0]  speed_zone,
  input  logic [7:0]  dout,
  output logic [7:0]  din,
  output logic        sync_n,
  output logic        byte_n,
  output logic        tr00_sense_n,
  output logic [6:0]  half_track,
  output logic        track_change,
  input  logic        track_ready,
  input  logic [12:0] track_len,
  output logic [12:0] buf_addr,
  output logic        buf_rd,
  input  logic [7:0]  buf_rdata,
  output logic        buf_wr,
  output logic [7:0]  buf_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SPIN = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  ph_q, state_q, state_d, zone_q, dph;
  logic [6:0]  ht_q, ht_d, cyc_q, last_cyc;
  logic [2:0]  bit_q;
  logic [12:0] pos_q;
  logic [13:0] pos_inc;
  logic [15:0] brdy_q;
  logic [7:0]  din_q;
  logic        tchg_q, seen_q, seen_d;
  logic        mode_q, soe_q, rd_pend_q, rd_soe_q, sync_n_q;
  logic        moved, bnd, enter, is_sync;

  always_comb begin
    dph   = stp - ph_q;
    ht_d  = ht_q;
    moved = 1'b0;
    if (dph == 2'd1 && ht_q != 7'(HT_MAX - 1)) begin
      ht_d  = ht_q + 7'd1;
      moved = 1'b1;
    end else if (dph == 2'd3 && ht_q != 7'd0) begin
      ht_d  = ht_q - 7'd1;
      moved = 1'b1;
    end
  end

  // Last cycle index of one bit cell: period is 128 - 8*zone.
  assign last_cyc = 7'd127 - {2'b00, zone_q, 3'b000};
  assign bnd      = (state_q == S_SPIN) && (bit_q == 3'd7) &&
                    (cyc_q == last_cyc);
  assign enter    = (state_q == S_IDLE) && mtr && track_ready &&
                    (track_len != 13'd0);
  assign pos_inc  = {1'b0, pos_q} + 14'd1;
  // Two consecutive FF bytes under the head form a sync mark.
  assign is_sync  = (buf_rdata == 8'hFF) && (din_q == 8'hFF);

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    if (moved) begin
      state_d = S_WAIT;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enter) state_d = S_SPIN;
        S_SPIN: if (!mtr || track_len == 13'd0) state_d = S_IDLE;
        S_WAIT: begin
          // Only a fresh load (ready low then high) releases the head.
          if (!track_ready)  seen_d  = 1'b1;
          else if (seen_q)   state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      ph_q      <= 2'd0;
      ht_q      <= 7'(HT_RESET);
      tchg_q    <= 1'b0;
      state_q   <= S_IDLE;
      seen_q    <= 1'b0;
      cyc_q     <= 7'd0;
      bit_q     <= 3'd0;
      pos_q     <= 13'd0;
      zone_q    <= 2'd0;
      mode_q    <= 1'b1;
      soe_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_soe_q  <= 1'b0;
      din_q     <= 8'h00;
      sync_n_q  <= 1'b1;
      brdy_q    <= 16'd0;
    end else begin
      ph_q      <= stp;
      ht_q      <= ht_d;
      tchg_q    <= moved;
      state_q   <= state_d;
      seen_q    <= seen_d;
      rd_pend_q <= buf_rd;
      rd_soe_q  <= soe_q;
      if (brdy_q != 16'd0) brdy_q <= brdy_q - 16'd1;
      if (enter) begin
        zone_q <= speed_zone;
        mode_q <= mode;
        soe_q  <= soe;
        if (pos_q >= track_len) pos_q <= 13'd0;
      end
      if (bnd || state_d != S_SPIN) begin
        cyc_q <= 7'd0;
        bit_q <= 3'd0;
      end else if (state_q == S_SPIN) begin
        if (cyc_q == last_cyc) begin
          cyc_q <= 7'd0;
          bit_q <= bit_q + 3'd1;
        end else begin
          cyc_q <= cyc_q + 7'd1;
        end
      end
      if (bnd) begin
        zone_q <= speed_zone;
        mode_q <= mode;
        soe_q  <= soe;
        pos_q  <= (pos_inc >= {1'b0, track_len}) ? 13'd0 : pos_inc[12:0];
      end
      if (buf_wr) begin
        sync_n_q <= 1'b1;
        if (soe_q) brdy_q <= 16'(BRDY_LEN);
      end
      if (rd_pend_q) begin
        din_q    <= buf_rdata;
        sync_n_q <= ~is_sync;
        if (rd_soe_q && !is_sync) brdy_q <= 16'(BRDY_LEN);
      end
    end
  end

  assign buf_rd       = bnd & mode_q;
  assign buf_wr       = bnd & ~mode_q;
  assign buf_addr     = pos_q;
  assign buf_wdata    = buf_wr ? dout : 8'h00;
  assign din          = din_q;
  assign sync_n       = sync_n_q;
  assign byte_n       = (brdy_q == 16'd0);
  assign half_track   = ht_q;
  assign tr00_sense_n = (ht_q != 7'd0);
  assign track_change = tchg_q;

endmodule

// File: tb/tb_c1541_drive_seq.sv
// tb_c1541_drive_seq: randomized scoreboard bench for c1541_drive_seq.
// Stimulus pushes expected buffer accesses; a monitor pops and compares.
module tb_c1541_drive_seq;
  localparam int HTM = 84;
  localparam int HTR = 34;
  localparam int BL  = 64;

  logic clk32 = 1'b0;
  logic reset_n = 1'b0;
  logic mtr = 1'b0, mode = 1'b1, soe = 1'b0;
  logic [1:0] stp = 2'd0, speed_zone = 2'd0;
  logic [7:0] dout = 8'h00;
  logic track_ready = 1'b0;
  logic [12:0] track_len = 13'd0;
  logic [7:0] buf_rdata = 8'h00;
  logic [7:0] din, buf_wdata;
  logic sync_n, byte_n, tr00_sense_n, track_change, buf_rd, buf_wr;
  logic [6:0] half_track;
  logic [12:0] buf_addr;

  c1541_drive_seq #(.HT_MAX(HTM), .HT_RESET(HTR), .BRDY_LEN(BL)) dut (
    .clk32(clk32), .reset_n(reset_n), .mtr(mtr), .mode(mode), .soe(soe),
    .stp(stp), .speed_zone(speed_zone), .dout(dout), .din(din),
    .sync_n(sync_n), .byte_n(byte_n), .tr00_sense_n(tr00_sense_n),
    .half_track(half_track), .track_change(track_change),
    .track_ready(track_ready), .track_len(track_len),
    .buf_addr(buf_addr), .buf_rd(buf_rd), .buf_rdata(buf_rdata),
    .buf_wr(buf_wr), .buf_wdata(buf_wdata)
  );

  always #16 clk32 = ~clk32;

  logic [7:0] mem [0:8191];
  logic [7:0] trk [0:8191];

  always @(posedge clk32) begin
    if (buf_rd) buf_rdata <= mem[buf_addr];
    if (buf_wr) mem[buf_addr] = buf_wdata;
  end

  typedef struct {
    bit wr; int addr; logic [7:0] data;
    bit sync; bit brdy; int gapk; int gap;
  } acc_t;

  acc_t expq[$];
  int total = 0, bad = 0;
  int cyc = 0, acc_seen = 0, pulses = 0, rise_cyc = 0;
  int ht_m = HTR, ph_m = 0, pos_m = 0, len_m = 0, npulse_m = 0;
  logic [7:0] last_din = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin : mon
    int last_acc; int chk_at; int low; acc_t e; acc_t pend;
    last_acc = -1; chk_at = -1; low = 0;
    forever begin
      @(negedge clk32);
      cyc++;
      if (track_change) pulses++;
      if (!reset_n) begin
        low = 0; chk_at = -1; last_acc = -1;
      end else begin
        if (buf_rd || buf_wr) begin
          acc_seen++;
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_access: got addr %0d want none",
                     buf_addr);
          end else begin
            e = expq.pop_front();
            chk("acc_is_write", 32'(buf_wr), 32'(e.wr));
            chk("acc_addr", 32'(buf_addr), e.addr);
            if (e.wr) chk("wdata", 32'(buf_wdata), 32'(e.data));
            if (e.gapk == 1) chk("slot_gap", cyc - last_acc, e.gap);
            if (e.gapk == 2)
              chk("resume_gap_in_window",
                  32'((cyc - rise_cyc >= e.gap - 4) &&
                      (cyc - rise_cyc <= e.gap + 4)), 32'd1);
            pend = e;
            chk_at = cyc + (e.wr ? 1 : 2);
          end
          last_acc = cyc;
        end
        if (cyc == chk_at) begin
          if (!pend.wr) chk("din", 32'(din), 32'(pend.data));
          chk("sync_n", 32'(sync_n), 32'(pend.sync));
          chk("byte_n", 32'(byte_n), 32'(!pend.brdy));
          chk_at = -1;
        end
        if (!byte_n) low++;
        else if (low != 0) begin
          chk("byte_n_len", low, BL);
          low = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  task automatic step(input logic [1:0] p);
    int d; int nh; bit pl;
    d = (int'(p) - ph_m) & 3;
    nh = ht_m;
    if (d == 1 && ht_m < HTM - 1) nh = ht_m + 1;
    else if (d == 3 && ht_m > 0) nh = ht_m - 1;
    pl = (nh != ht_m);
    if (pl) npulse_m++;
    ht_m = nh; ph_m = int'(p);
    stp = p;
    @(posedge clk32);
    @(negedge clk32);
    chk("track_change", 32'(track_change), 32'(pl));
    chk("half_track", 32'(half_track), ht_m);
    chk("tr00_sense_n", 32'(tr00_sense_n), 32'(ht_m != 0));
    tick(1);
  endtask

  task automatic load(input int len);
    track_ready = 1'b0;
    track_len = 13'(len);
    len_m = len;
    for (int i = 0; i < len; i++) mem[i] = trk[i];
    tick(3);
    track_ready = 1'b1;
    rise_cyc = cyc;
    tick(2);
  endtask

  task automatic plan(input int n, input int zone, input bit md,
                      input bit so, input logic [7:0] wd, input int gk);
    acc_t e; logic [7:0] b;
    if (pos_m >= len_m) pos_m = 0;
    for (int k = 0; k < n; k++) begin
      e.wr = !md; e.addr = pos_m;
      if (md) begin
        b = trk[pos_m];
        e.data = b;
        e.sync = !(b == 8'hFF && last_din == 8'hFF);
        e.brdy = e.sync && so;
        last_din = b;
      end else begin
        e.data = wd; trk[pos_m] = wd;
        e.sync = 1'b1; e.brdy = so;
      end
      e.gapk = (k == 0) ? gk : 1;
      e.gap = 8 * (128 - 8 * zone);
      expq.push_back(e);
      pos_m = (pos_m + 1) % len_m;
    end
    speed_zone = 2'(zone); mode = md; soe = so; dout = wd;
  endtask

  task automatic wait_acc(input int n);
    int tgt; int t;
    tgt = acc_seen + n; t = 0;
    while (acc_seen < tgt && t < (n + 2) * 1100) begin
      @(posedge clk32);
      t++;
    end
    #1;
    if (acc_seen < tgt) begin
      total++; bad++;
      $display("FAIL access_timeout: got %0d want %0d", acc_seen, tgt);
      expq.delete();
    end
  endtask

  task automatic run(input int n);
    mtr = 1'b1;
    wait_acc(n);
    mtr = 1'b0;
    tick(80);
  endtask

  initial begin : main
    int snap; int len; int zn; bit md; bit so;
    tick(3);
    reset_n = 1'b1;
    @(negedge clk32);
    chk("rst_half_track", 32'(half_track), HTR);
    chk("rst_tr00_n", 32'(tr00_sense_n), 1);
    chk("rst_track_change", 32'(track_change), 0);
    chk("rst_sync_n", 32'(sync_n), 1);
    chk("rst_byte_n", 32'(byte_n), 1);
    chk("rst_din", 32'(din), 0);
    chk("rst_buf_rd", 32'(buf_rd), 0);
    chk("rst_buf_wr", 32'(buf_wr), 0);
    chk("rst_buf_addr", 32'(buf_addr), 0);
    chk("rst_buf_wdata", 32'(buf_wdata), 0);
    tick(1);

    step(2'd1); step(2'd2); step(2'd3); step(2'd1);
    chk("pulses_inward", pulses, npulse_m);
    for (int i = 0; i < 40; i++) step(2'((ph_m + 3) & 3));
    chk("pulses_outward", pulses, npulse_m);
    for (int i = 0; i < 20; i++) step(2'($urandom_range(0, 3)));
    chk("pulses_random", pulses, npulse_m);

    trk[0] = 8'h55; trk[1] = 8'hAA; trk[2] = 8'h12;
    load(3);
    plan(6, 3, 1'b1, 1'b1, 8'h00, 0);
    run(6);

    trk[0] = 8'hFF; trk[1] = 8'hFF; trk[2] = 8'hFF; trk[3] = 8'h52;
    load(4);
    plan(4, 0, 1'b1, 1'b1, 8'h00, 0);
    run(4);

    for (int i = 0; i < 100; i++) trk[i] = 8'($urandom);
    load(100);
    plan(5, 2, 1'b0, 1'b1, 8'h3C, 0);
    run(5);

    plan(2, 1, 1'b1, 1'b1, 8'h00, 0);
    mtr = 1'b1;
    wait_acc(2);
    step(2'((ph_m + 1) & 3));
    snap = acc_seen;
    tick(2600);
    chk("halted_while_ready_high", acc_seen, snap);
    track_ready = 1'b0;
    tick(3);
    track_ready = 1'b1;
    rise_cyc = cyc;
    plan(3, 1, 1'b1, 1'b1, 8'h00, 2);
    wait_acc(3);
    mtr = 1'b0;
    tick(80);

    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(2, 6);
      for (int i = 0; i < len; i++)
        trk[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      load(len);
      zn = $urandom_range(0, 3);
      md = 1'($urandom);
      so = 1'($urandom);
      plan($urandom_range(3, 5), zn, md, so, 8'($urandom), 0);
      run(expq.size());
    end

    for (int i = 0; i < 8; i++) trk[i] = 8'h11;
    load(8);
    plan(1, 3, 1'b1, 1'b1, 8'h00, 0);
    mtr = 1'b1;
    wait_acc(1);
    tick(3);
    reset_n = 1'b0; stp = 2'd0; mtr = 1'b0;
    tick(1);
    @(negedge clk32);
    chk("midpulse_rst_byte_n", 32'(byte_n), 1);
    chk("midpulse_rst_din", 32'(din), 0);
    chk("midpulse_rst_sync_n", 32'(sync_n), 1);
    chk("midpulse_rst_half_track", 32'(half_track), HTR);
    chk("midpulse_rst_buf_rd", 32'(buf_rd), 0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    chk("pulses_final", pulses, npulse_m);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
